uart_rx: RTL

// - 8N1 UART receiver, counterpart to the project's UART transmitter; same clk domain, same bit timing.
// - Samples async serial line rx_i and recovers bytes LSB-first.
// - Presents each byte on a 1-entry valid/ready holding register.
// - Flags framing errors (bad stop bit) and overruns (unread byte overwritten attempt).

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART constants: frame width, default bit timing and receiver FSM codes.
// Kept common with the transmitter so both sides agree on encodings.
package uart_rx_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_CLKS_PER_BIT_DEFAULT = 104;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream handshake between the UART receiver and its consumer.
// master = producer of bytes, slave = consumer.
interface uart_rx_if
   import uart_rx_pkg::*;
();

   uart_byte_t data;
   logic       valid;
   logic       ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so an idle-high line does not look like a start bit.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff_q <= {2{RST_VAL}};
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry holding register.
// Framing errors pulse for one cycle; overruns are sticky until cleared.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx_i,
   uart_rx_if.master rx_if,
   output logic     frame_err_o,
   output logic     overrun_o,
   input  logic     err_clr_i,
   output logic     busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

   logic          rx_s;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   uart_byte_t    shreg_q, shreg_d;
   uart_byte_t    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;

   uart_sync2 #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (rx_i),
      .q_o  (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = ovr_q;

      if (valid_q && rx_if.ready) valid_d = 1'b0;
      if (err_clr_i) ovr_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               shreg_d   = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  // leave mid stop bit so a following start edge is caught
                  state_d = ST_IDLE;
                  if (!valid_q || rx_if.ready) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign rx_if.data  = data_q;
   assign rx_if.valid = valid_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule
